// File: rtl/snn_pkg.sv
// ----------------------------------------------------------------------------
// snn_pkg : shared state encoding and default geometry for the spiking layer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package snn_pkg;

   localparam int DEF_N_IN      = 784;
   localparam int DEF_N_OUT     = 32;
   localparam int DEF_W_WIDTH   = 8;
   localparam int DEF_ACC_WIDTH = 18;
   localparam int DEF_IN_AW     = 10;
   localparam int DEF_WT_AW     = 15;
   localparam int DEF_OUT_AW    = 5;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } snn_state_e;

endpackage

`default_nettype wire

// File: rtl/snn_mac_acc.sv
// ----------------------------------------------------------------------------
// snn_mac_acc : spike-gated signed accumulator with threshold compare
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module snn_mac_acc
   import snn_pkg::*;
#(
   parameter int                          W_WIDTH   = DEF_W_WIDTH,
   parameter int                          ACC_WIDTH = DEF_ACC_WIDTH,
   parameter logic signed [ACC_WIDTH-1:0] THRESH    = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      vld,
   input  logic                      spike,
   input  logic signed [W_WIDTH-1:0] wt,
   output logic                      fire
);

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] wt_ext;

   assign wt_ext = {{(ACC_WIDTH-W_WIDTH){wt[W_WIDTH-1]}}, wt};

   // Width is sized so the worst-case sum cannot wrap; no saturation needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (vld && spike) begin
         acc <= acc + wt_ext;
      end
   end

   assign fire = (acc >= THRESH);

endmodule

`default_nettype wire

// File: rtl/snn_layer_seq.sv
// ----------------------------------------------------------------------------
// snn_layer_seq : streams spikes/weights from RAM, accumulates and fires per neuron
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module snn_layer_seq
   import snn_pkg::*;
#(
   parameter int                          N_IN      = DEF_N_IN,
   parameter int                          N_OUT     = DEF_N_OUT,
   parameter int                          W_WIDTH   = DEF_W_WIDTH,
   parameter int                          ACC_WIDTH = DEF_ACC_WIDTH,
   parameter logic signed [ACC_WIDTH-1:0] THRESH    = '0,
   parameter int                          IN_AW     = DEF_IN_AW,
   parameter int                          WT_AW     = DEF_WT_AW,
   parameter int                          OUT_AW    = DEF_OUT_AW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [IN_AW-1:0]          in_addr,
   input  logic                      in_q,
   output logic [WT_AW-1:0]          wt_addr,
   input  logic signed [W_WIDTH-1:0] wt_q,
   output logic [OUT_AW-1:0]         out_addr,
   output logic                      out_data,
   output logic                      out_we
);

   localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
   localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

   snn_state_e        state;
   logic [IN_AW-1:0]  i;
   logic [OUT_AW-1:0] j;
   logic [WT_AW-1:0]  wptr;
   logic              vld;
   logic              clr;
   logic              fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         i       <= '0;
         j       <= '0;
         wptr    <= '0;
         in_addr <= '0;
         wt_addr <= '0;
         vld     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  i       <= '0;
                  j       <= '0;
                  wptr    <= '0;
                  in_addr <= '0;
                  wt_addr <= '0;
                  vld     <= 1'b0;
                  state   <= RUN;
               end
            end
            // Address registers run one step ahead of i/wptr so the RAM sees
            // address i during the cycle i is current; they hold on the last beat.
            RUN: begin
               vld  <= 1'b1;
               wptr <= wptr + 1'b1;
               if (i == I_LAST) begin
                  i     <= '0;
                  state <= DRAIN;
               end else begin
                  i       <= i + 1'b1;
                  in_addr <= i + 1'b1;
                  wt_addr <= wptr + 1'b1;
               end
            end
            DRAIN: begin
               vld   <= 1'b0;
               state <= WRITE;
            end
            WRITE: begin
               if (j == J_LAST) begin
                  state <= DONE;
               end else begin
                  j       <= j + 1'b1;
                  in_addr <= '0;
                  wt_addr <= wptr;
                  state   <= RUN;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign clr = ((state == IDLE) && start) || (state == WRITE);

   snn_mac_acc #(
      .W_WIDTH   (W_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .THRESH    (THRESH)
   ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .vld   (vld),
      .spike (in_q),
      .wt    (wt_q),
      .fire  (fire)
   );

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign out_we   = (state == WRITE);
   assign out_data = (state == WRITE) && fire;
   assign out_addr = j;

endmodule

`default_nettype wire

// File: tb/tb_snn_layer_seq.sv
// ----------------------------------------------------------------------------
// tb_snn_layer_seq : scoreboard bench, small 4x2 layer plus default 784x32 layer
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_snn_layer_seq;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   // ---------------- small layer: N_IN=4, N_OUT=2 ----------------
   logic              rst_a, start_a, busy_a, done_a, in_q_a, out_data_a, out_we_a;
   logic [1:0]        in_addr_a;
   logic [2:0]        wt_addr_a;
   logic [0:0]        out_addr_a;
   logic signed [7:0] wt_q_a;
   bit                sp_a [4];
   int                wt_a [8];

   always @(posedge clk) begin
      in_q_a <= sp_a[in_addr_a];
      wt_q_a <= 8'(wt_a[wt_addr_a]);
   end

   snn_layer_seq #(
      .N_IN (4), .N_OUT (2), .W_WIDTH (8), .ACC_WIDTH (18), .THRESH ('0),
      .IN_AW (2), .WT_AW (3), .OUT_AW (1)
   ) dut_a (
      .clk (clk), .rst (rst_a), .start (start_a), .busy (busy_a), .done (done_a),
      .in_addr (in_addr_a), .in_q (in_q_a), .wt_addr (wt_addr_a), .wt_q (wt_q_a),
      .out_addr (out_addr_a), .out_data (out_data_a), .out_we (out_we_a)
   );

   int exp_addr_a [$];
   int exp_sum_a  [$];
   int done_cnt_a = 0;
   int es_a;

   task automatic push_exp_a();
      for (int n = 0; n < 2; n++) begin
         int s;
         s = 0;
         for (int k = 0; k < 4; k++) if (sp_a[k]) s += wt_a[n*4+k];
         exp_addr_a.push_back(n);
         exp_sum_a.push_back(s);
      end
   endtask

   always @(negedge clk) begin
      if (done_a) done_cnt_a++;
      if (out_we_a) begin
         check_eq("a_we_expected", exp_addr_a.size() != 0, 1);
         if (exp_addr_a.size() != 0) begin
            es_a = exp_sum_a.pop_front();
            check_eq("a_out_addr", out_addr_a, exp_addr_a.pop_front());
            check_eq("a_acc", dut_a.u_mac.acc, es_a);
            check_eq("a_out_data", out_data_a, es_a >= 0);
         end
      end
   end

   task automatic run_a(input int pulse_at, input string tag);
      int cyc;
      push_exp_a();
      start_a = 1'b1;
      cyc = 0;
      while (done_a !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start_a = (cyc == pulse_at);
         if (cyc == 1) check_eq({tag, "_busy_c1"}, busy_a, 1);
      end
      start_a = 1'b0;
      check_eq({tag, "_done_cycle"}, cyc, 13);
      @(negedge clk);
      check_eq({tag, "_done_width"}, done_a, 0);
      check_eq({tag, "_idle_after"}, busy_a, 0);
      @(negedge clk);
      check_eq({tag, "_no_restart"}, busy_a, 0);
      check_eq({tag, "_drained"}, exp_addr_a.size(), 0);
   endtask

   // ---------------- default layer: 784x32 ----------------
   logic              rst_b, start_b, busy_b, done_b, in_q_b, out_data_b, out_we_b;
   logic [9:0]        in_addr_b;
   logic [14:0]       wt_addr_b;
   logic [4:0]        out_addr_b;
   logic signed [7:0] wt_q_b;

   always @(posedge clk) begin
      in_q_b <= 1'b1;
      wt_q_b <= 8'h80;
   end

   snn_layer_seq dut_b (
      .clk (clk), .rst (rst_b), .start (start_b), .busy (busy_b), .done (done_b),
      .in_addr (in_addr_b), .in_q (in_q_b), .wt_addr (wt_addr_b), .wt_q (wt_q_b),
      .out_addr (out_addr_b), .out_data (out_data_b), .out_we (out_we_b)
   );

   int exp_addr_b [$];
   int last_wt_b = 0;
   int steps_b   = 0;
   int bad_b     = 0;

   always @(negedge clk) begin
      if (busy_b && int'(wt_addr_b) != last_wt_b) begin
         steps_b++;
         if (int'(wt_addr_b) != last_wt_b + 1) bad_b++;
         last_wt_b = int'(wt_addr_b);
      end
      if (out_we_b) begin
         check_eq("b_we_expected", exp_addr_b.size() != 0, 1);
         if (exp_addr_b.size() != 0) begin
            check_eq("b_out_addr", out_addr_b, exp_addr_b.pop_front());
            check_eq("b_acc", dut_b.u_mac.acc, -100352);
            check_eq("b_out_data", out_data_b, 0);
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int d0;
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      sp_a = '{1, 1, 1, 1};
      wt_a = '{3, -1, 2, -5, 10, 0, 0, 0};
      repeat (2) @(negedge clk);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_out_we", out_we_a, 0);
      check_eq("rst_out_data", out_data_a, 0);
      check_eq("rst_in_addr", in_addr_a, 0);
      check_eq("rst_wt_addr", wt_addr_a, 0);
      check_eq("rst_out_addr", out_addr_a, 0);
      check_eq("rst_acc", dut_a.u_mac.acc, 0);
      check_eq("rst_busy_b", busy_b, 0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      run_a(0, "t1");

      sp_a = '{1, 0, 1, 0};
      wt_a = '{-7, 100, 7, 100, -1, 5, 0, 0};
      run_a(0, "t2");

      sp_a = '{0, 1, 1, 1};
      wt_a = '{50, -20, -30, 49, -128, 127, 1, 0};
      run_a(5, "t3");

      // reset in the WRITE cycle of neuron 0: nothing may be written
      sp_a = '{1, 1, 1, 1};
      wt_a = '{3, -1, 2, -5, 10, 0, 0, 0};
      d0 = done_cnt_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_a = 1'b1;
      @(negedge clk);
      check_eq("t4_busy", busy_a, 0);
      check_eq("t4_out_we", out_we_a, 0);
      check_eq("t4_acc", dut_a.u_mac.acc, 0);
      rst_a = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("t4_no_done", done_cnt_a, d0);
      check_eq("t4_stays_idle", busy_a, 0);
      run_a(0, "t4_restart");

      // start held high: back-to-back passes, one IDLE cycle apart
      push_exp_a();
      push_exp_a();
      start_a = 1'b1;
      cyc = 0;
      while (done_a !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      check_eq("t5_done1", cyc, 13);
      @(negedge clk); cyc++;
      check_eq("t5_idle_gap", busy_a, 0);
      @(negedge clk); cyc++;
      check_eq("t5_restart", busy_a, 1);
      start_a = 1'b0;
      while (done_a !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
      check_eq("t5_done2", cyc, 27);
      repeat (2) @(negedge clk);
      check_eq("t5_drained", exp_addr_a.size(), 0);
      check_eq("t5_idle", busy_a, 0);

      // full-size layer, all spikes, all weights -128
      for (int n = 0; n < 32; n++) exp_addr_b.push_back(n);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      cyc = 1;
      check_eq("b_wt_addr_c1", wt_addr_b, 0);
      while (done_b !== 1'b1 && cyc < 30000) begin @(negedge clk); cyc++; end
      check_eq("b_done_cycle", cyc, 25153);
      check_eq("b_drained", exp_addr_b.size(), 0);
      check_eq("b_wt_steps", steps_b, 25087);
      check_eq("b_wt_step_errs", bad_b, 0);
      check_eq("b_wt_last", last_wt_b, 25087);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/snn_layer_seq.md
# snn_layer_seq

Sequencer and accumulator for one fully connected spiking layer. It streams input spikes and signed weights out of two single-port synchronous RAMs. It accumulates one output neuron at a time and writes a 1-bit output spike per neuron into an output RAM. It sits directly downstream of the input and weight RAMs (1-cycle registered-address read) and upstream of the output-spike RAM.

## Interface
- N_IN, 784: input neurons per output neuron.
- N_OUT, 32: output neurons.
- W_WIDTH, 8: signed weight width.
- ACC_WIDTH, 18: signed accumulator width; must be at least W_WIDTH + clog2(N_IN).
- THRESH, 0: signed firing threshold, ACC_WIDTH bits.
- IN_AW, 10 / WT_AW, 15 / OUT_AW, 5: address widths of the input, weight and output RAMs.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE inclusive.
- done  out  1  one-cycle pulse at end of pass.
- in_addr  out  IN_AW  input-spike RAM address.
- in_q  in  1  input-spike RAM data, valid one cycle after in_addr.
- wt_addr  out  WT_AW  weight RAM address.
- wt_q  in  W_WIDTH  signed weight, valid one cycle after wt_addr.
- out_addr  out  OUT_AW  output RAM address.
- out_data  out  1  output spike.
- out_we  out  1  output RAM write enable.

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- **IDLE**
  - On start: clear the counters i=0, j=0 and wptr=0, clear acc, go to RUN.
  - start is ignored in every state other than IDLE.
- **RUN**
  - Drive in_addr=i and wt_addr=wptr. Increment i and wptr every cycle.
  - Set the registered flag vld=1 for the next cycle.
  - When i==N_IN-1, go to DRAIN with i reset to 0.
- **Accumulate**
  - Each cycle that vld=1 and in_q=1: acc <= acc + sign_extend(wt_q).
  - If vld=1 and in_q=0, acc holds.
  - No saturation. The width rule guarantees no overflow.
- **DRAIN**
  - vld is still 1, so the last product is accumulated.
  - No new address is issued; the addresses hold their last value. vld clears.
  - Go to WRITE.
- **WRITE**
  - Assert out_we=1, out_addr=j, out_data=(acc >= THRESH), comparison signed.
  - Clear acc.
  - If j==N_OUT-1, go to DONE. Otherwise increment j and go to RUN.
- **wptr**
  - wptr is never reset between neurons. It runs continuously from 0 to N_IN*N_OUT-1, so weights are laid out row-major by output neuron.
- **DONE**
  - done=1 for one cycle, then go to IDLE.

## Timing
- Reset values: state IDLE, busy 0, done 0, out_we 0, out_data 0, all addresses 0, acc 0, vld 0, counters 0.
- start at cycle 0: RUN occupies cycles 1..N_IN, DRAIN is cycle N_IN+1, WRITE is cycle N_IN+2.
- Per-neuron cost: N_IN+2 cycles.
- done is asserted at cycle N_OUT*(N_IN+2)+1.
- Throughput: one multiply-accumulate per cycle in steady state.
- out_we is high for exactly one cycle per neuron, N_OUT pulses per pass.
- All outputs are registered or decoded from state/counter registers. There is no combinational path from in_q or wt_q to any output except through acc.
- Reset asserted mid-pass: everything returns to reset values immediately. No further out_we, no done. A new start is required.
- start held high continuously: a new pass begins on the cycle after DONE (IDLE samples it).

## Structure
- Shared package snn_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, WRITE, DONE);
  - default widths W_WIDTH, ACC_WIDTH, IN_AW, WT_AW, OUT_AW;
  - N_IN and N_OUT defaults.
- One sub-module, snn_mac_acc, holds the acc register, the vld-gated conditional add, the clear and the threshold compare.
- The FSM and counters stay in snn_layer_seq.

## Test plan
- Bench config: N_IN=4, N_OUT=2, THRESH=0, and RAM models with 1-cycle read latency.
- Spikes 1,1,1,1 and weights neuron0 = 3,-1,2,-5, neuron1 = 10,0,0,0 -> writes out_addr0=0 (sum -1), then out_addr1=1; done at cycle 13.
- Spikes 1,0,1,0 and weights neuron0 = -7,100,7,100 -> sum 0 equals THRESH -> out_data=1. This checks the >= comparison and that spike-masked weights are ignored.
- Default params, all spikes 1, all weights -128 -> acc reaches -100352 with no wrap; out_data=0 for all 32 neurons.
  - wt_addr sweeps 0..25087 exactly once.
- Assert rst at cycle 6 of a pass -> busy=0 and out_we=0 next edge, and no done.
  - A fresh start then completes the full expected sequence.
- Pulse start again while busy -> ignored; the pass timing is unchanged.
  - start held high -> back-to-back passes with exactly one IDLE cycle between them.
